// File: rtl/dht11_pkg.sv
//============================================================
// dht11_pkg: shared DHT11 protocol state encoding, frame length and timing. Rev 1.0
//============================================================
`default_nettype none

package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_LOW = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_ACK_LOW   = 3'd3,
        ST_ACK_HIGH  = 3'd4,
        ST_BIT_LOW   = 3'd5,
        ST_BIT_HIGH  = 3'd6,
        ST_END_LOW   = 3'd7
    } dht11_state_t;

    localparam int FRAME_BITS = 40;

    // Nominal microsecond timings, also used by the host-side sensor logic
    localparam int DEF_START_MIN_US     = 18000;
    localparam int DEF_RESPONSE_WAIT_US = 30;
    localparam int DEF_ACK_LOW_US       = 80;
    localparam int DEF_ACK_HIGH_US      = 80;
    localparam int DEF_BIT_LOW_US       = 50;
    localparam int DEF_BIT0_HIGH_US     = 26;
    localparam int DEF_BIT1_HIGH_US     = 70;

    function automatic logic [7:0] dht11_checksum(input logic [7:0] hi, input logic [7:0] hd,
                                                  input logic [7:0] ti, input logic [7:0] td);
        logic [7:0] sum;
        sum = hi + hd + ti + td;
        return sum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/us_tick_gen.sv
//============================================================
// us_tick_gen: free-running prescaler emitting a one-cycle pulse every microsecond. Rev 1.0
//============================================================
`default_nettype none

module us_tick_gen #(
    parameter int CLK_FREQ_HZ = 50000000
) (
    input  logic clock,
    input  logic reset,
    output logic us_tick
);

    localparam int DIV = (CLK_FREQ_HZ / 1000000 > 0) ? CLK_FREQ_HZ / 1000000 : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            us_tick <= 1'b0;
        end else if (count == LAST) begin
            count   <= '0;
            us_tick <= 1'b1;
        end else begin
            count   <= count + 1'b1;
            us_tick <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dht11_responder.sv
//============================================================
// dht11_responder: DHT11 sensor emulator answering host start pulses on an open-drain line. Rev 1.0
//============================================================
`default_nettype none

module dht11_responder
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 50000000,
    parameter int START_MIN_US     = DEF_START_MIN_US,
    parameter int RESPONSE_WAIT_US = DEF_RESPONSE_WAIT_US,
    parameter int ACK_LOW_US       = DEF_ACK_LOW_US,
    parameter int ACK_HIGH_US      = DEF_ACK_HIGH_US,
    parameter int BIT_LOW_US       = DEF_BIT_LOW_US,
    parameter int BIT0_HIGH_US     = DEF_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US     = DEF_BIT1_HIGH_US
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire        transmission_line,
    input  logic [7:0] humidity_int,
    input  logic [7:0] humidity_dec,
    input  logic [7:0] temperature_int,
    input  logic [7:0] temperature_dec,
    input  logic       inject_checksum_error,
    output logic       busy,
    output logic       frame_done,
    output logic       start_rejected,
    output logic       line_drive_low
);

    localparam logic [15:0] START_MIN = 16'(START_MIN_US);
    localparam logic [15:0] RESP_WAIT = 16'(RESPONSE_WAIT_US);
    localparam logic [15:0] ACK_LOW   = 16'(ACK_LOW_US);
    localparam logic [15:0] ACK_HIGH  = 16'(ACK_HIGH_US);
    localparam logic [15:0] BIT_LOW   = 16'(BIT_LOW_US);
    localparam logic [15:0] BIT0_HIGH = 16'(BIT0_HIGH_US);
    localparam logic [15:0] BIT1_HIGH = 16'(BIT1_HIGH_US);
    localparam logic [5:0]  LAST_BIT  = 6'(FRAME_BITS - 1);

    logic         us_tick;
    logic [1:0]   line_sync;
    logic         line_in;
    dht11_state_t state;
    logic [15:0]  dur;
    logic [15:0]  phase_len;
    logic         phase_end;
    logic [39:0]  shreg;
    logic [5:0]   bit_cnt;
    logic [7:0]   checksum;

    us_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .us_tick (us_tick)
    );

    assign transmission_line = line_drive_low ? 1'b0 : 1'bz;
    assign line_in           = line_sync[1];

    // Released line idles high, so the synchroniser resets to 1 to avoid a false start
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) line_sync <= 2'b11;
        else        line_sync <= {line_sync[0], transmission_line};
    end

    always_comb begin
        phase_len = 16'd1;
        case (state)
            ST_WAIT_RESP: phase_len = RESP_WAIT;
            ST_ACK_LOW:   phase_len = ACK_LOW;
            ST_ACK_HIGH:  phase_len = ACK_HIGH;
            ST_BIT_LOW:   phase_len = BIT_LOW;
            ST_BIT_HIGH:  phase_len = shreg[39] ? BIT1_HIGH : BIT0_HIGH;
            ST_END_LOW:   phase_len = BIT_LOW;
            default:      phase_len = 16'd1;
        endcase
    end

    assign phase_end = us_tick && (dur >= phase_len - 16'd1);
    assign checksum  = dht11_checksum(humidity_int, humidity_dec, temperature_int, temperature_dec)
                       ^ {8{inject_checksum_error}};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            dur            <= '0;
            shreg          <= '0;
            bit_cnt        <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            start_rejected <= 1'b0;
            line_drive_low <= 1'b0;
        end else begin
            frame_done     <= 1'b0;
            start_rejected <= 1'b0;
            if (us_tick && dur != 16'hFFFF) dur <= dur + 16'd1;

            case (state)
                ST_IDLE: begin
                    if (!line_in) begin
                        state <= ST_START_LOW;
                        dur   <= '0;
                    end
                end
                ST_START_LOW: begin
                    if (line_in) begin
                        dur <= '0;
                        if (dur >= START_MIN) begin
                            state <= ST_WAIT_RESP;
                        end else begin
                            start_rejected <= 1'b1;
                            state          <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (phase_end) begin
                        shreg          <= {humidity_int, humidity_dec, temperature_int,
                                           temperature_dec, checksum};
                        bit_cnt        <= '0;
                        busy           <= 1'b1;
                        line_drive_low <= 1'b1;
                        state          <= ST_ACK_LOW;
                        dur            <= '0;
                    end
                end
                ST_ACK_LOW: begin
                    if (phase_end) begin
                        line_drive_low <= 1'b0;
                        state          <= ST_ACK_HIGH;
                        dur            <= '0;
                    end
                end
                ST_ACK_HIGH, ST_BIT_HIGH: begin
                    if (phase_end) begin
                        line_drive_low <= 1'b1;
                        dur            <= '0;
                        if (state == ST_ACK_HIGH) begin
                            state <= ST_BIT_LOW;
                        end else begin
                            shreg   <= {shreg[38:0], 1'b0};
                            bit_cnt <= bit_cnt + 6'd1;
                            state   <= (bit_cnt == LAST_BIT) ? ST_END_LOW : ST_BIT_LOW;
                        end
                    end
                end
                ST_BIT_LOW: begin
                    if (phase_end) begin
                        line_drive_low <= 1'b0;
                        state          <= ST_BIT_HIGH;
                        dur            <= '0;
                    end
                end
                ST_END_LOW: begin
                    if (phase_end) begin
                        line_drive_low <= 1'b0;
                        frame_done     <= 1'b1;
                        busy           <= 1'b0;
                        state          <= ST_IDLE;
                        dur            <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
